// File: rtl/addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// addr_gen_pkg
//   Shared definitions for the programmable address generator:
//   - ag_state_e    : sequencer state (AG_IDLE / AG_RUN)
//   - AG_ADDR_W_DEF : default address width
//   - AG_CNT_W_DEF  : default index/length width
// ---------------------------------------------------------------------------
package addr_gen_pkg;

    localparam int unsigned AG_ADDR_W_DEF = 13;
    localparam int unsigned AG_CNT_W_DEF  = 13;

    typedef enum logic {
        AG_IDLE = 1'b0,
        AG_RUN  = 1'b1
    } ag_state_e;

endpackage

// File: rtl/addr_gen_prog_if.sv
// ---------------------------------------------------------------------------
// addr_gen_prog_if
//   Control/config and address stream bundle of the address generator.
//   master : the controlling side (drives start/stop/config/ack, reads addr)
//   slave  : the generator itself
//   Signals:
//     start, stop          - (re)start / abort requests
//     base, stride, last,
//     wrap                 - sequence config, sampled on start
//     ack                  - consumer accepted the current addr
//     addr, idx            - current address and its index in the pass
//     status               - 1 while addresses are available
//     done                 - one-cycle pulse after the last address of a pass
// ---------------------------------------------------------------------------
interface addr_gen_prog_if #(
    parameter int unsigned ADDR_W = addr_gen_pkg::AG_ADDR_W_DEF,
    parameter int unsigned CNT_W  = addr_gen_pkg::AG_CNT_W_DEF
);

    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  last;
    logic              wrap;
    logic              ack;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  idx;
    logic              status;
    logic              done;

    modport master (
        output start, stop, base, stride, last, wrap, ack,
        input  addr, idx, status, done
    );

    modport slave (
        input  start, stop, base, stride, last, wrap, ack,
        output addr, idx, status, done
    );

endinterface

// File: rtl/addr_gen_prog.sv
// ---------------------------------------------------------------------------
// addr_gen_prog
//   Programmable address generator for memory-streaming ports. Emits
//   base + k*stride (mod 2^ADDR_W) for k = 0..last, advancing one step per
//   accepted ack. Supports one-shot and circular (wrap) passes, restart via
//   start and abort via stop. With AUTO_START=1 it leaves reset streaming
//   0..2^ADDR_W-1 one-shot, standing in for a plain address counter.
//
//   Ports:
//     clk  - clock
//     rstx - asynchronous active-low reset
//     bus  - addr_gen_prog_if.slave (config/handshake in, address stream out)
//
//   Edge priority: start > stop > ack. All outputs come straight from flops.
// ---------------------------------------------------------------------------
module addr_gen_prog
    import addr_gen_pkg::*;
#(
    parameter int unsigned ADDR_W     = AG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = AG_CNT_W_DEF,
    parameter bit          AUTO_START = 1'b1
) (
    input logic                  clk,
    input logic                  rstx,
    addr_gen_prog_if.slave       bus
);

    // Reset image: AUTO_START selects "running 0,1,2,... one-shot over the
    // whole index range" versus "idle with everything cleared".
    localparam ag_state_e         RstState  = AUTO_START ? AG_RUN : AG_IDLE;
    localparam logic [ADDR_W-1:0] RstStride = ADDR_W'(AUTO_START);
    localparam logic [CNT_W-1:0]  RstLast   = {CNT_W{AUTO_START}};

    // -----------------------------------------------------------------------
    // State and config registers
    // -----------------------------------------------------------------------
    ag_state_e         state_q,  state_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [CNT_W-1:0]  idx_q,    idx_d;
    logic              done_q,   done_d;
    logic [ADDR_W-1:0] base_q,   base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]  last_q,   last_d;
    logic              wrap_q,   wrap_d;

    // -----------------------------------------------------------------------
    // Datapath: one adder, one incrementer, one comparator
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_step;
    logic [CNT_W-1:0]  idx_step;
    logic              at_last;

    // Modulo-2^ADDR_W wrap of the address is intentional.
    assign addr_step = addr_q + stride_q;
    assign idx_step  = idx_q + CNT_W'(1);
    assign at_last   = (idx_q == last_q);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        base_d   = base_q;
        stride_d = stride_q;
        last_d   = last_q;
        wrap_d   = wrap_q;

        if (bus.start) begin
            // Any in-flight pass is dropped silently.
            base_d   = bus.base;
            stride_d = bus.stride;
            last_d   = bus.last;
            wrap_d   = bus.wrap;
            addr_d   = bus.base;
            idx_d    = '0;
            state_d  = AG_RUN;
        end else if (bus.stop) begin
            // Abort keeps addr/idx so the consumer can see where it stopped.
            state_d = AG_IDLE;
        end else begin
            unique case (state_q)
                AG_RUN: begin
                    if (bus.ack) begin
                        if (at_last) begin
                            done_d = 1'b1;
                            if (wrap_q) begin
                                addr_d = base_q;
                                idx_d  = '0;
                            end else begin
                                // One-shot end: hold final addr/idx.
                                state_d = AG_IDLE;
                            end
                        end else begin
                            addr_d = addr_step;
                            idx_d  = idx_step;
                        end
                    end
                end
                AG_IDLE: begin
                    // ack is ignored while idle.
                end
                default: begin
                    state_d = AG_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state_q  <= RstState;
            addr_q   <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            base_q   <= '0;
            stride_q <= RstStride;
            last_q   <= RstLast;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            last_q   <= last_d;
            wrap_q   <= wrap_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.addr   = addr_q;
    assign bus.idx    = idx_q;
    assign bus.status = (state_q == AG_RUN);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_addr_gen_prog.sv
// ---------------------------------------------------------------------------
// tb_addr_gen_prog
//   Self-checking bench for addr_gen_prog (ADDR_W=CNT_W=13, AUTO_START=1).
//   Expected outputs come from hand-written vectors and from a reference
//   model that tracks the sequence as base + k*stride (mod 2^13).
// ---------------------------------------------------------------------------
module tb_addr_gen_prog;

    localparam int W    = 13;
    localparam int MASK = (1 << W) - 1;

    logic clk;
    logic rstx;

    addr_gen_prog_if #(.ADDR_W(W), .CNT_W(W)) bus ();

    addr_gen_prog #(
        .ADDR_W    (W),
        .CNT_W     (W),
        .AUTO_START(1'b1)
    ) dut (
        .clk (clk),
        .rstx(rstx),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // ---------------- reference model ----------------
    bit m_run, m_done, m_wrap;
    int m_base, m_stride, m_last, m_k;

    function automatic void model_reset();
        m_run    = 1'b1;
        m_done   = 1'b0;
        m_wrap   = 1'b0;
        m_base   = 0;
        m_stride = 1;
        m_last   = MASK;
        m_k      = 0;
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (bus.start) begin
            m_base   = int'(bus.base);
            m_stride = int'(bus.stride);
            m_last   = int'(bus.last);
            m_wrap   = bus.wrap;
            m_k      = 0;
            m_run    = 1'b1;
        end else if (bus.stop) begin
            m_run = 1'b0;
        end else if (m_run && bus.ack) begin
            if (m_k == m_last) begin
                m_done = 1'b1;
                if (m_wrap) m_k = 0;
                else        m_run = 1'b0;
            end else begin
                m_k++;
            end
        end
    endfunction

    function automatic int model_addr();
        longint a;
        a = longint'(m_base) + longint'(m_k) * longint'(m_stride);
        return int'(a % (longint'(MASK) + 1));
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".addr"},   32'(bus.addr),   32'(model_addr()));
        chk({tag, ".idx"},    32'(bus.idx),    32'(m_k));
        chk({tag, ".status"}, 32'(bus.status), 32'(m_run));
        chk({tag, ".done"},   32'(bus.done),   32'(m_done));
    endtask

    // One clock edge: advance the model, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input int st, input int sp, input int ak, input int b,
                         input int s, input int l, input int wr);
        bus.start  = 1'(st);
        bus.stop   = 1'(sp);
        bus.ack    = 1'(ak);
        bus.base   = W'(b);
        bus.stride = W'(s);
        bus.last   = W'(l);
        bus.wrap   = 1'(wr);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int st, sp, ak, b, s, l, wr;
        int e_addr, e_idx, e_status, e_done;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(int st, int sp, int ak, int b, int s, int l, int wr,
                                int ea, int ei, int es, int ed);
        vec_t v;
        v.st = st; v.sp = sp; v.ak = ak; v.b = b; v.s = s; v.l = l; v.wr = wr;
        v.e_addr = ea; v.e_idx = ei; v.e_status = es; v.e_done = ed;
        return v;
    endfunction

    int wexp[12];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstx  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // ---------- reset state (still in reset) ----------
        repeat (3) @(posedge clk);
        #1;
        chk_model("rst");
        @(negedge clk);
        rstx = 1'b1;
        #1;
        chk_model("rst_rel");

        // ---------- AUTO_START sweep: 8192 acks ----------
        bus.ack = 1'b1;
        for (int i = 1; i <= 8192; i++) begin
            step();
            if (i < 8192) begin
                if (32'(bus.addr) !== 32'(i) || bus.done !== 1'b0 || bus.status !== 1'b1)
                    chk_model("sweep");
                else
                    n_cmp++;
            end
        end
        chk("sweep_end.addr",   32'(bus.addr),   32'd8191);
        chk("sweep_end.done",   32'(bus.done),   32'd1);
        chk("sweep_end.status", 32'(bus.status), 32'd0);
        step();
        chk("sweep_hold.addr", 32'(bus.addr), 32'd8191);
        chk("sweep_hold.done", 32'(bus.done), 32'd0);
        chk_model("sweep_hold");

        // ---------- table-driven vectors ----------
        tbl[0]  = mk(1, 0, 0, 100, 3, 3, 0,   100, 0, 1, 0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 0, 0,     103, 1, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,     103, 1, 1, 0);
        tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0,     106, 2, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,     106, 2, 1, 0);
        tbl[5]  = mk(0, 0, 1, 0, 0, 0, 0,     109, 3, 1, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0,     109, 3, 1, 0);
        tbl[7]  = mk(0, 0, 1, 0, 0, 0, 0,     109, 3, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,     109, 3, 0, 0);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 0,     109, 3, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 0,     109, 3, 0, 0);
        tbl[11] = mk(1, 0, 0, 500, 7, 9, 1,   500, 0, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 0,     507, 1, 1, 0);
        tbl[13] = mk(0, 0, 1, 0, 0, 0, 0,     514, 2, 1, 0);
        tbl[14] = mk(1, 0, 1, 1000, 5, 2, 0,  1000, 0, 1, 0);
        tbl[15] = mk(0, 0, 1, 0, 0, 0, 0,     1005, 1, 1, 0);
        tbl[16] = mk(0, 1, 1, 0, 0, 0, 0,     1005, 1, 0, 0);
        tbl[17] = mk(0, 0, 1, 0, 0, 0, 0,     1005, 1, 0, 0);
        tbl[18] = mk(1, 0, 0, 42, 9, 0, 0,    42, 0, 1, 0);
        tbl[19] = mk(0, 0, 1, 0, 0, 0, 0,     42, 0, 0, 1);
        tbl[20] = mk(0, 0, 1, 0, 0, 0, 0,     42, 0, 0, 0);
        tbl[21] = mk(1, 0, 0, 42, 9, 0, 1,    42, 0, 1, 0);
        tbl[22] = mk(0, 0, 1, 0, 0, 0, 0,     42, 0, 1, 1);
        tbl[23] = mk(0, 0, 1, 0, 0, 0, 0,     42, 0, 1, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,     42, 0, 1, 0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].ak, tbl[i].b, tbl[i].s, tbl[i].l, tbl[i].wr);
            step();
            chk($sformatf("vec%0d.addr", i),   32'(bus.addr),   32'(tbl[i].e_addr));
            chk($sformatf("vec%0d.idx", i),    32'(bus.idx),    32'(tbl[i].e_idx));
            chk($sformatf("vec%0d.status", i), 32'(bus.status), 32'(tbl[i].e_status));
            chk($sformatf("vec%0d.done", i),   32'(bus.done),   32'(tbl[i].e_done));
        end
        chk_model("tbl_sync");

        // ---------- wrap across the top of the address space ----------
        wexp = '{8188, 8190, 0, 2, 4, 8188, 8190, 0, 2, 4, 8188, 8190};
        drive(1, 0, 0, 8188, 2, 4, 1);
        step();
        chk("wrap0.addr", 32'(bus.addr), 32'(wexp[0]));
        drive(0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 12; i++) begin
            step();
            chk($sformatf("wrap%0d.addr", i),   32'(bus.addr),   32'(wexp[i]));
            chk($sformatf("wrap%0d.done", i),   32'(bus.done),   32'((i % 5) == 0));
            chk($sformatf("wrap%0d.status", i), 32'(bus.status), 32'd1);
        end
        chk_model("wrap_sync");

        // ---------- async reset in the middle of a wrap pass ----------
        step();
        step();
        rstx = 1'b0;
        #1;
        model_reset();
        chk_model("arst_now");
        @(posedge clk);
        #1;
        chk_model("arst_hold");
        @(negedge clk);
        rstx = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("arst_after%0d.addr", i), 32'(bus.addr), 32'(i));
            chk_model("arst_after");
        end

        // ---------- randomized traffic vs. model ----------
        for (int i = 0; i < 3000; i++) begin
            int l;
            l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MASK) : $urandom_range(0, 6);
            drive(($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 19) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  $urandom_range(0, MASK), $urandom_range(0, MASK), l,
                  $urandom_range(0, 1));
            step();
            chk_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addr_gen_prog.md
# addr_gen_prog

Programmable address generator for TTA memory-streaming ports. It produces a sequence of `ADDR_W`-bit addresses of the form base + k·stride, advancing one step per accepted `ack`. It supports one-shot and wrap (circular) modes, restart and abort. With `AUTO_START=1` it powers up streaming 0..2^ADDR_W−1 one-shot, replacing the fixed 13-bit address counter used by the current accelerator interfaces.

## Interface
Parameters:
- `ADDR_W`, 13: address width.
- `CNT_W`, 13: index/length width.
- `AUTO_START`, 1: 1 = leave reset in RUN with base=0, stride=1, last=all-ones, wrap=0.

Ports:
- `clk`  in  1  clock.
- `rstx`  in  1  reset, asynchronous, active-low.
- `start`  in  1  load config and (re)start sequence.
- `stop`  in  1  abort to IDLE, no `done`.
- `base`  in  `ADDR_W`  first address (sampled on `start`).
- `stride`  in  `ADDR_W`  increment, unsigned, modulo 2^ADDR_W (sampled on `start`).
- `last`  in  `CNT_W`  number of addresses minus one (sampled on `start`).
- `wrap`  in  1  1 = circular, 0 = one-shot (sampled on `start`).
- `ack`  in  1  consumer accepted current `addr`.
- `addr`  out  `ADDR_W`  current address.
- `idx`  out  `CNT_W`  index of current address.
- `status`  out  1  1 while in RUN (addresses available).
- `done`  out  1  one-cycle pulse when the final address of a pass is accepted.

## Operation
- States: IDLE, RUN. The config registers (`base_r`, `stride_r`, `last_r`, `wrap_r`) are loaded only on `start`.
- Reset values:
  - `AUTO_START=1`: state RUN, `addr`=0, `idx`=0, `status`=1, `done`=0, config = {0, 1, all-ones, 0}.
  - `AUTO_START=0`: state IDLE, `status`=0; all other outputs and config registers are 0.
- Priority per edge: `start` > `stop` > `ack`.
- `start` in any state: load config, `addr`←`base`, `idx`←0, state RUN, `done`←0. An in-flight sequence is discarded without `done`.
- `stop` (no `start`): state IDLE, `addr`/`idx` hold, no `done`.
- RUN, `ack`=1, `idx`≠`last_r`: `idx`←`idx`+1, `addr`←`addr`+`stride_r`. The addition truncates to `ADDR_W` bits and wraps silently.
- RUN, `ack`=1, `idx`=`last_r`:
  - `done`←1.
  - `wrap_r`=1: `addr`←`base_r`, `idx`←0, stay in RUN.
  - `wrap_r`=0: state IDLE, `addr`/`idx` hold the final values.
- `ack` in IDLE is ignored.
- `last`=0 is legal: a single address, and every accepted `ack` ends a pass.
- `status` = (state==RUN), registered.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- `start` sampled at edge n: `status`=1, `addr`=`base`, `idx`=0 valid after edge n.
- Each `ack`=1 while `status`=1 advances `addr` by exactly one step at that edge. Back-to-back `ack` gives one address per cycle.
- `done` is high for exactly the cycle after the edge that accepted index `last_r`. In one-shot mode `status` falls in that same cycle.
- Wrap mode with continuous `ack`: `done` pulses every (`last_r`+1) cycles with no bubble.
- `rstx` asserted mid-sequence forces the reset values immediately (asynchronous). Release follows the `AUTO_START` rule.

## Structure
- Shared package `addr_gen_pkg`: state enum (`AG_IDLE`, `AG_RUN`) and default width constants `AG_ADDR_W_DEF`=13 and `AG_CNT_W_DEF`=13.
- Single module; no sub-module warranted. Keep the datapath as one adder (`addr`+`stride_r`), one incrementer and one comparator (`idx`==`last_r`).

## Test plan
- Reset with `AUTO_START=1`, `ack` held high 8192 cycles → `addr` 0..8191, `done` pulses once after the 8192nd `ack`, then `status`=0 and `addr` holds 8191.
- `start` with base=100, stride=3, last=3, wrap=0; `ack` every other cycle → `addr` 100, 103, 106, 109; `done` one cycle; IDLE; later `ack` pulses leave `addr`=109.
- wrap=1, base=8188, stride=2, last=4, `ack` continuous → `addr` 8188, 8190, 0, 2, 4, 8188, …; `done` every 5 cycles; `status` stays 1.
- `start` and `ack` asserted in the same cycle mid-sequence → new `base` appears, no `done`, `idx`=0. `stop` and `ack` in the same cycle → IDLE with `addr` unchanged.
- last=0, base=42 → every `ack` yields `done`. In one-shot mode, the first `ack` moves to IDLE.
- `rstx` low for 1 cycle in the middle of a wrap sequence → outputs immediately show the reset values; the sequence does not resume with the old config.
